// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter: clock inhibit, request-to-send, 11-clock frame, ACK check.
// Define PS2_TX_TIMEOUT_EN to compile in a transaction timeout that ends a stalled transfer with err=1.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       qzt_clk,
  input  logic       rst_n,
  input  logic [7:0] data,
  input  logic       send,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {
    IDLE, INHIBIT, REQ, SHIFT, ACK, WAIT_REL, FIN
  } state_t;

  localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;

  if (INHIBIT_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("ps2_host_tx: INHIBIT_CYCLES and TIMEOUT_CYCLES must be at least 1");
  end

  state_t           r_state, w_state_nxt;
  logic [INH_W-1:0] r_inh_cnt, w_inh_cnt_nxt;
  logic [3:0]       r_bit_cnt, w_bit_cnt_nxt;
  logic [8:0]       r_shift, w_shift_nxt;
  logic             r_err, w_err_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;
  logic             r_clk_oe, w_clk_oe_nxt;
  logic             r_data_oe, w_data_oe_nxt;

  logic [1:0]       r_clk_sync, r_data_sync;
  logic             r_clk_prev;
  logic             w_clk_fall, w_lines_idle, w_inh_last, w_inh_prelast;

`ifdef PS2_TX_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TMO_W-1:0] r_tmo_cnt, w_tmo_cnt_nxt;
  logic             w_tmo_hit;
  assign w_tmo_hit = (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`endif

  // Two-flop synchronizers; a third flop on the clock line gives the previous level for edge detection.
  always_ff @(posedge qzt_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clk_sync  <= '0;
      r_data_sync <= '0;
      r_clk_prev  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the pre-edge values, forming a true shift chain.
      r_clk_sync  <= {r_clk_sync[0], ps2_clk_in};
      r_data_sync <= {r_data_sync[0], ps2_data_in};
      r_clk_prev  <= r_clk_sync[1];
    end
  end

  assign w_clk_fall    = r_clk_prev & ~r_clk_sync[1];
  assign w_lines_idle  = r_clk_sync[1] & r_data_sync[1];
  assign w_inh_last    = (r_inh_cnt == INH_W'(INHIBIT_CYCLES - 1));
  assign w_inh_prelast = (INHIBIT_CYCLES > 1) && (r_inh_cnt == INH_W'(INHIBIT_CYCLES - 2));

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    w_state_nxt   = r_state;
    w_inh_cnt_nxt = r_inh_cnt;
    w_bit_cnt_nxt = r_bit_cnt;
    w_shift_nxt   = r_shift;
    w_err_nxt     = r_err;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;
    w_clk_oe_nxt  = r_clk_oe;
    w_data_oe_nxt = r_data_oe;
`ifdef PS2_TX_TIMEOUT_EN
    w_tmo_cnt_nxt = r_tmo_cnt;
`endif
    unique case (r_state)
      IDLE: begin
        if (send) begin
          w_shift_nxt   = {~^data, data};
          w_err_nxt     = 1'b0;
          w_busy_nxt    = 1'b1;
          w_inh_cnt_nxt = '0;
          w_bit_cnt_nxt = '0;
          w_clk_oe_nxt  = 1'b1;
          w_data_oe_nxt = (INHIBIT_CYCLES == 1);
          w_state_nxt   = INHIBIT;
        end
      end
      INHIBIT: begin
        if (w_inh_last) begin
          w_clk_oe_nxt  = 1'b0;
          w_data_oe_nxt = 1'b1;
          w_state_nxt   = REQ;
`ifdef PS2_TX_TIMEOUT_EN
          w_tmo_cnt_nxt = '0;
`endif
        end else begin
          w_inh_cnt_nxt = r_inh_cnt + 1'b1;
          w_data_oe_nxt = w_inh_prelast;
        end
      end
      REQ: begin
        if (w_clk_fall) begin
          w_data_oe_nxt = ~r_shift[0];
          w_shift_nxt   = {1'b1, r_shift[8:1]};
          w_bit_cnt_nxt = 4'd1;
          w_state_nxt   = SHIFT;
        end
      end
      SHIFT: begin
        // Ones shift in from the top, so the tenth edge drives the released stop bit.
        if (w_clk_fall) begin
          w_data_oe_nxt = ~r_shift[0];
          w_shift_nxt   = {1'b1, r_shift[8:1]};
          w_bit_cnt_nxt = r_bit_cnt + 1'b1;
          if (r_bit_cnt == 4'd9) w_state_nxt = ACK;
        end
      end
      ACK: begin
        if (w_clk_fall) begin
          w_err_nxt     = r_data_sync[1];
          w_bit_cnt_nxt = r_bit_cnt + 1'b1;
          w_state_nxt   = WAIT_REL;
        end
      end
      WAIT_REL: begin
        if (w_lines_idle) begin
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
          w_state_nxt = FIN;
        end
      end
      FIN:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
`ifdef PS2_TX_TIMEOUT_EN
    if (r_state inside {REQ, SHIFT, ACK, WAIT_REL}) begin
      w_tmo_cnt_nxt = r_tmo_cnt + 1'b1;
      if (w_tmo_hit) begin
        w_clk_oe_nxt  = 1'b0;
        w_data_oe_nxt = 1'b0;
        w_err_nxt     = 1'b1;
        w_busy_nxt    = 1'b0;
        w_done_nxt    = 1'b1;
        w_state_nxt   = FIN;
      end
    end
`endif
  end

  always_ff @(posedge qzt_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_inh_cnt <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_err     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_clk_oe  <= 1'b0;
      r_data_oe <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
      r_tmo_cnt <= '0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_inh_cnt <= w_inh_cnt_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_shift   <= w_shift_nxt;
      r_err     <= w_err_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_clk_oe  <= w_clk_oe_nxt;
      r_data_oe <= w_data_oe_nxt;
`ifdef PS2_TX_TIMEOUT_EN
      r_tmo_cnt <= w_tmo_cnt_nxt;
`endif
    end
  end

  assign ps2_clk_oe  = r_clk_oe;
  assign ps2_data_oe = r_data_oe;
  assign busy        = r_busy;
  assign done        = r_done;
  assign err         = r_err;

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
Parameters:
REQ-001 SHALL provide parameter INHIBIT_CYCLES, default 5000, the number of clock-low inhibit cycles (100 us at 50 MHz).
REQ-002 SHALL provide parameter TIMEOUT_CYCLES, default 750000, the transaction timeout in cycles (15 ms at 50 MHz).

Ports:
REQ-003 SHALL have port qzt_clk, input, 1 bit: the 50 MHz system clock; all state is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port data, input, 8 bits: the byte to send to the device, e.g. 8'hF4 for mouse enable.
REQ-006 SHALL have port send, input, 1 bit: a one-cycle start strobe.
REQ-007 SHALL have port ps2_clk_in, input, 1 bit: raw PS/2 clock line level (asynchronous).
REQ-008 SHALL have port ps2_data_in, input, 1 bit: raw PS/2 data line level (asynchronous).
REQ-009 SHALL have port ps2_clk_oe, output, 1 bit: 1 pulls the clock line low, 0 releases it; the top level maps 0 to Z.
REQ-010 SHALL have port ps2_data_oe, output, 1 bit: 1 pulls the data line low, 0 releases it.
REQ-011 SHALL have port busy, output, 1 bit: high from send acceptance until done.
REQ-012 SHALL have port done, output, 1 bit: a one-cycle end-of-transaction pulse.
REQ-013 SHALL have port err, output, 1 bit: error status, valid while done is high and held until the next accepted send.

Function
REQ-014 SHALL synchronize ps2_clk_in and ps2_data_in through 2 flops each; a falling edge is sync_prev=1 and sync=0.
REQ-015 SHALL use the states IDLE, INHIBIT, REQ, SHIFT, ACK, WAIT_REL, FIN.
REQ-016 IDLE: send=1 SHALL latch data, compute odd parity (~^data), clear err, set busy and go to INHIBIT on the next cycle.
REQ-017 SHALL ignore send while busy=1, with no relatch and no effect.
REQ-018 INHIBIT: ps2_clk_oe=1 and ps2_data_oe=0 for exactly INHIBIT_CYCLES cycles; on the last cycle ps2_data_oe=1, then go to REQ.
REQ-019 REQ: ps2_clk_oe=0 and ps2_data_oe=1 (start bit); the first synchronized falling edge SHALL drive bit0 and go to SHIFT.
REQ-020 SHIFT: each falling edge SHALL advance a 4-bit bit counter and drive, in order, bit1..bit7, then parity, then stop (release data); ps2_data_oe SHALL equal the inverse of the bit value.
REQ-021 SHIFT: after the stop-bit edge (10th falling edge) SHALL go to ACK.
REQ-022 ACK: on the 11th falling edge SHALL sample synchronized data; 0 = ACK, 1 = NACK (err=1); then go to WAIT_REL.
REQ-023 WAIT_REL: SHALL wait until both synchronized lines are 1, then go to FIN.
REQ-024 FIN: done=1 and busy=0 for one cycle, then IDLE.
REQ-025 SHALL never drive ps2_clk_oe=1 outside INHIBIT.
REQ-026 Parity SHALL be odd over the 8 data bits plus the parity bit.

Reset
REQ-027 rst_n=0 SHALL immediately force state=IDLE, ps2_clk_oe=0, ps2_data_oe=0, busy=0, done=0, err=0, with all counters and the shift register at 0, including mid-transaction.
REQ-028 After reset release, the block SHALL accept send on the first clock edge.

Configuration
REQ-029 With `PS2_TX_TIMEOUT_EN defined, SHALL run a timeout counter from REQ entry; reaching TIMEOUT_CYCLES in REQ, SHIFT, ACK or WAIT_REL SHALL release both lines, set err=1 and go to FIN.
REQ-030 Without PS2_TX_TIMEOUT_EN, SHALL compile no timeout counter and wait indefinitely for device clocks; err SHALL then come only from NACK.

Verification
REQ-031 Reset then send with data=8'hF4 and a device model clocking at 12.5 kHz with ACK -> clock held low 5000 cycles, line bits 0,0,0,1,0,1,1,1,1,0(parity),1(stop), done pulse, err=0.
REQ-032 data=8'h00 with a device NACK (data high on edge 11) -> parity bit 1, done with err=1.
REQ-033 Second send during SHIFT with data=8'hFF -> ignored; the transmitted byte is still the first.
REQ-034 rst_n low at bit 4 -> both oe low in the same cycle (asynchronous), busy=0; next send completes normally.
REQ-035 With PS2_TX_TIMEOUT_EN and no device clock after INHIBIT -> at 750000 cycles, lines released, done with err=1.
REQ-036 Device holds data low after ACK for 200 cycles -> done asserted only after data goes high, plus the synchronizer delay.
